multicycle_main_control: RTL and testbench

Main control finite-state machine for the multicycle RV32I-subset datapath. It is the producer side of the ALU-operation interface: it decodes the 7-bit instruction opcode and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the 2-bit `alu_op` consumed by the ALU control decoder, plus every datapath enable and mux select. Instruction and data memory share a single port, handled with a req/ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/opcode_class_decode.sv | 23 ++
 rtl/multicycle_main_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_main_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control path: states, opcodes,
// ALU operation codes and datapath mux selects.
package cpu_ctrl_pkg;

    localparam int OPCODE_WIDTH = 7;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_I_ALU = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 7'b1101111;

    // Bit positions of the one-hot opcode class vector; legal classes come first.
    localparam int CLS_R       = 0;
    localparam int CLS_I_ALU   = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BEQ     = 4;
    localparam int CLS_JAL     = 5;
    localparam int CLS_ILLEGAL = 6;
    localparam int NUM_LEGAL   = 6;
    localparam int NUM_CLASSES = 7;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: one bit per legal instruction class plus an
// illegal bit that is set when no legal class matches.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [NUM_CLASSES-1:0]  op_class
);

    localparam logic [OPCODE_WIDTH-1:0] CLASS_OPCODE [NUM_LEGAL] =
        '{OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL};

    logic [NUM_LEGAL-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_LEGAL; gi++) begin : g_match
            assign hit[gi] = (opcode == CLASS_OPCODE[gi]);
        end
    endgenerate

    assign op_class = {~|hit, hit};

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable, mux select and alu_op.
module multicycle_main_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_write,
    output logic [1:0]          mem_to_reg,
    output logic                illegal,
    output logic [3:0]          state
);

    state_t                 state_reg;
    logic                   illegal_reg;
    logic [NUM_CLASSES-1:0] op_class;

    // The branch condition is applied in the datapath by pc_write_cond & zero.
    logic unused_zero;
    assign unused_zero = zero;

    opcode_class_decode u_opcode_class_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_FETCH;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: if (mem_ready) state_reg <= ST_DECODE;
                ST_DECODE: begin
                    if (op_class[CLS_ILLEGAL]) begin
                        state_reg   <= ST_ILLEGAL;
                        illegal_reg <= 1'b1;
                    end else if (op_class[CLS_LOAD] || op_class[CLS_STORE]) begin
                        state_reg <= ST_MEM_ADDR;
                    end else if (op_class[CLS_R]) begin
                        state_reg <= ST_EXEC_R;
                    end else if (op_class[CLS_I_ALU]) begin
                        state_reg <= ST_EXEC_I;
                    end else if (op_class[CLS_BEQ]) begin
                        state_reg <= ST_BRANCH;
                    end else begin
                        state_reg <= ST_JAL;
                    end
                end
                ST_MEM_ADDR: begin
                    if (op_class[CLS_LOAD]) begin
                        state_reg <= ST_MEM_READ;
                    end else if (op_class[CLS_STORE]) begin
                        state_reg <= ST_MEM_WRITE;
                    end else begin
                        state_reg   <= ST_ILLEGAL;
                        illegal_reg <= 1'b1;
                    end
                end
                ST_MEM_READ:  if (mem_ready) state_reg <= ST_MEM_WB;
                ST_MEM_WRITE: if (mem_ready) state_reg <= ST_FETCH;
                ST_EXEC_R, ST_EXEC_I: state_reg <= ST_ALU_WB;
                ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL: state_reg <= ST_FETCH;
                ST_ILLEGAL: state_reg <= ST_ILLEGAL;
                default: begin
                    // Unused encodings are treated as a corrupted sequence.
                    state_reg   <= ST_ILLEGAL;
                    illegal_reg <= 1'b1;
                end
            endcase
        end
    end

    // Everything is forced low while reset is held, so a pending memory
    // request is withdrawn in the same cycle reset is applied.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        reg_write     = 1'b0;
        mem_to_reg    = WB_ALUOUT;
        illegal       = 1'b0;
        state         = 4'd0;
        if (rst_n) begin
            state   = state_reg;
            illegal = illegal_reg;
            case (state_reg)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                ST_MEM_READ: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = WB_MDR;
                end
                ST_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    i_or_d  = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_FUNCT;
                end
                ST_ALU_WB: reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a     = SRC_A_RS1;
                    alu_src_b     = SRC_B_RS2;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_ALUOUT;
                end
                ST_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    reg_write  = 1'b1;
                    mem_to_reg = WB_PC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized scoreboard bench for multicycle_main_control: stimulus queues the
// expected per-cycle outputs and instruction latencies; a monitor checks them.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_op, alu_src_a, alu_src_b, mem_to_reg;
    logic       reg_write, illegal;
    logic [3:0] state;

    multicycle_main_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src, alu_op, src_a, src_b;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } vec_t;

    vec_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   force_zero = 1'b0;

    // Class order: R, I-ALU, LOAD, STORE, BEQ, JAL
    logic [6:0] opc_tab [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111};
    int         base_lat [6] = '{4, 4, 5, 4, 3, 3};

    // Per-state output table, straight from the state descriptions.
    function automatic vec_t spec_outputs(int st, bit rdy, bit rst_high);
        vec_t v;
        v = '0;
        if (!rst_high) return v;
        v.st = st[3:0];
        case (st)
            0:  begin v.mem_req = 1; v.src_b = 1; v.ir_write = rdy; v.pc_write = rdy; end
            1:  begin v.src_a = 2; v.src_b = 2; end
            2:  begin v.src_a = 1; v.src_b = 2; end
            3:  begin v.mem_req = 1; v.i_or_d = 1; end
            4:  begin v.reg_write = 1; v.mem_to_reg = 1; end
            5:  begin v.mem_req = 1; v.mem_we = 1; v.i_or_d = 1; end
            6:  begin v.src_a = 1; v.src_b = 0; v.alu_op = 2; end
            7:  begin v.src_a = 1; v.src_b = 2; v.alu_op = 2; end
            8:  begin v.reg_write = 1; end
            9:  begin v.src_a = 1; v.alu_op = 1; v.pc_write_cond = 1; v.pc_src = 1; end
            10: begin v.pc_write = 1; v.pc_src = 2; v.reg_write = 1; v.mem_to_reg = 2; end
            15: begin v.illegal = 1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic cycle(int st, bit rdy, bit rst_val, logic [6:0] opc);
        @(posedge clk);
        #1;
        rst_n     = rst_val;
        mem_ready = rdy;
        opcode    = opc;
        zero      = force_zero ? 1'b1 : 1'($urandom);
        exp_q.push_back(spec_outputs(st, rdy, rst_val));
    endtask

    task automatic mem_phase(int st, int waits, logic [6:0] opc);
        for (int w = 0; w <= waits; w++) cycle(st, (w == waits), 1'b1, opc);
    endtask

    task automatic run_instr(int cls, int fw, int mw);
        logic [6:0] opc;
        opc = opc_tab[cls];
        for (int w = 0; w <= fw; w++) cycle(0, (w == fw), 1'b1, 7'($urandom));
        cycle(1, 1'($urandom), 1'b1, opc);
        case (cls)
            0: begin cycle(6, 1'($urandom), 1'b1, opc); cycle(8, 1'($urandom), 1'b1, opc); end
            1: begin cycle(7, 1'($urandom), 1'b1, opc); cycle(8, 1'($urandom), 1'b1, opc); end
            2: begin
                cycle(2, 1'($urandom), 1'b1, opc);
                mem_phase(3, mw, opc);
                cycle(4, 1'($urandom), 1'b1, opc);
            end
            3: begin
                cycle(2, 1'($urandom), 1'b1, opc);
                mem_phase(5, mw, opc);
            end
            4: cycle(9, 1'($urandom), 1'b1, opc);
            default: cycle(10, 1'($urandom), 1'b1, opc);
        endcase
        lat_q.push_back(base_lat[cls] + fw + mw);
        $display("instr opcode=%b fetch_wait=%0d mem_wait=%0d expected_cycles=%0d",
                 opc, fw, mw, base_lat[cls] + fw + mw);
    endtask

    // Monitor: per-cycle output compare plus instruction length between FETCH entries.
    int   instr_cnt = 0;
    int   prev_st = 0;
    vec_t got;
    vec_t want;
    int   want_lat;
    always @(negedge clk) begin
        cyc++;
        got = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_src, alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg, illegal};
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs cyc=%0d state got=%0d exp=%0d vector got=%h exp=%h",
                         cyc, got.st, want.st, got, want);
            end
        end
        if (!rst_n) begin
            instr_cnt = 0;
            prev_st   = 0;
        end else begin
            if (state == 4'd0 && prev_st != 0) begin
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency cyc=%0d got=%0d exp=none", cyc, instr_cnt);
                end else begin
                    want_lat = lat_q.pop_front();
                    if (instr_cnt != want_lat) begin
                        errors++;
                        $display("FAIL latency cyc=%0d got=%0d exp=%0d", cyc, instr_cnt, want_lat);
                    end
                end
                instr_cnt = 0;
            end
            instr_cnt++;
            prev_st = int'(state);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cls, fw, mw;
        // Reset held two cycles with stray mem_ready, then release into FETCH.
        cycle(0, 1'b1, 1'b0, 7'd0);
        cycle(0, 1'b0, 1'b0, 7'd0);

        run_instr(0, 0, 0);            // R, zero wait
        run_instr(2, 0, 2);            // LOAD, two read wait cycles
        force_zero = 1'b1;
        run_instr(4, 0, 0);            // BEQ with zero=1
        force_zero = 1'b0;
        run_instr(1, 1, 0);
        run_instr(5, 0, 0);
        run_instr(3, 0, 0);

        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 5);
            fw  = $urandom_range(0, 2);
            mw  = (cls == 2 || cls == 3) ? $urandom_range(0, 3) : 0;
            run_instr(cls, fw, mw);
        end

        // STORE abandoned by reset in MEM_WRITE, with mem_ready in the reset cycle.
        $display("instr opcode=0100011 abandoned by reset in MEM_WRITE");
        cycle(0, 1'b1, 1'b1, 7'($urandom));
        cycle(1, 1'b0, 1'b1, 7'b0100011);
        cycle(2, 1'b1, 1'b1, 7'b0100011);
        cycle(5, 1'b0, 1'b1, 7'b0100011);
        cycle(0, 1'b1, 1'b0, 7'b0100011);
        run_instr(0, 0, 0);

        // Illegal opcode: sticky until reset.
        $display("instr opcode=1111111 illegal, held 10 cycles then reset");
        cycle(0, 1'b1, 1'b1, 7'($urandom));
        cycle(1, 1'($urandom), 1'b1, 7'b1111111);
        for (int n = 0; n < 10; n++) cycle(15, 1'($urandom), 1'b1, 7'($urandom));
        cycle(0, 1'b1, 1'b0, 7'd0);
        run_instr(1, 0, 0);
        run_instr(2, 1, 1);

        // Idle FETCH cycles close out the last instruction's latency.
        cycle(0, 1'b0, 1'b1, 7'($urandom));
        cycle(0, 1'b0, 1'b1, 7'($urandom));
        @(posedge clk);
        @(posedge clk);

        checks++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d pending exp=0/0", exp_q.size(), lat_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
